mem_lsu_master: RTL

//  Initiator side of the byte-addressed sim memory port 0 (wr_en/wr_mask/addr/data_in/data_out_0).

---
 rtl/mem_lsu_master.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_lsu_master.sv
// Load/store initiator for byte-addressed sim memory port 0: one request at a time, size-extended loads, store acks.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of performing them byte-wise.
module mem_lsu_master #(
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr_en,
  output logic [3:0]  mem_wr_mask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready; the
  // producer holds valid and payload stable until then. req_ready is high only
  // in IDLE outside reset; resp_valid stays high in RESP until resp_ready.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state;
  logic        we_r;
  logic        uns_r;
  logic [1:0]  size_r;
  logic        wr_en_r;

  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        misalign;
  logic        req_bad;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [31:0] load_ext;

  // 33-bit end address so a request near 2^32 carries out and is rejected.
  always_comb begin
    nbytes   = 3'd1;
    misalign = 1'b0;
    case (req_size)
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
    end_addr = {1'b0, req_addr} + {30'd0, nbytes};
`ifdef MISALIGN_TRAP_EN
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
    req_bad = (req_size == 2'b11) || (end_addr > 33'(MEM_SIZE)) || misalign;
  end

  // Store data is right-justified on the request side, left-justified on memory.
  always_comb begin
    lane_mask = 4'b1000;
    lane_data = {req_wdata[7:0], 24'd0};
    case (req_size)
      2'b01: begin
        lane_mask = 4'b1100;
        lane_data = {req_wdata[15:0], 16'd0};
      end
      2'b10: begin
        lane_mask = 4'b1111;
        lane_data = req_wdata;
      end
      default: begin
        lane_mask = 4'b1000;
        lane_data = {req_wdata[7:0], 24'd0};
      end
    endcase
  end

  always_comb begin
    load_ext = mem_rdata;
    case (size_r)
      2'b00:   load_ext = {{24{~uns_r & mem_rdata[31]}}, mem_rdata[31:24]};
      2'b01:   load_ext = {{16{~uns_r & mem_rdata[31]}}, mem_rdata[31:16]};
      default: load_ext = mem_rdata;
    endcase
  end

  assign req_ready = (state == IDLE) && !rst;
  assign mem_wr_en = wr_en_r && !rst;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      we_r        <= 1'b0;
      uns_r       <= 1'b0;
      size_r      <= 2'b00;
      wr_en_r     <= 1'b0;
      mem_wr_mask <= 4'd0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_r       <= req_we;
            uns_r      <= req_unsigned;
            size_r     <= req_size;
            resp_rdata <= 32'd0;
            if (req_bad) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              resp_err    <= 1'b0;
              mem_addr    <= req_addr;
              wr_en_r     <= req_we;
              mem_wr_mask <= req_we ? lane_mask : 4'd0;
              mem_wdata   <= req_we ? lane_data : 32'd0;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wr_en_r     <= 1'b0;
          mem_wr_mask <= 4'd0;
          if (we_r) begin
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          resp_rdata <= load_ext;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
